ysyx_25050141_mem_arb: RTL



---
 rtl/ysyx_25050141_mem_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ysyx_25050141_mem_arb.sv
// ysyx_25050141 memory arbiter: round-robin IF/ME sharing of a single
// memory port, one outstanding transaction at a time.
module ysyx_25050141_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  input  logic                if_rsp_ready,
  output logic [DATA_W-1:0]   if_rsp_rdata,
  output logic                if_rsp_err,
  input  logic                me_req_valid,
  output logic                me_req_ready,
  input  logic [ADDR_W-1:0]   me_req_addr,
  input  logic                me_req_wen,
  input  logic [DATA_W-1:0]   me_req_wdata,
  input  logic [DATA_W/8-1:0] me_req_wstrb,
  output logic                me_rsp_valid,
  input  logic                me_rsp_ready,
  output logic [DATA_W-1:0]   me_rsp_rdata,
  output logic                me_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  input  logic                mem_rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic                sel;
  logic                last;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic in_idle, in_req, in_resp;
  logic grant_if, grant_me;
  logic req_hs, rsp_hs;

  // Outputs are masked during reset so the reset cycle is fully quiet.
  assign in_idle = !rst && (state == IDLE);
  assign in_req  = !rst && (state == REQ);
  assign in_resp = !rst && (state == RESP);

  // On a tie the master that was not served last wins.
  assign grant_if = if_req_valid && (!me_req_valid || last);
  assign grant_me = me_req_valid && (!if_req_valid || !last);

  assign if_req_ready = in_idle && grant_if;
  assign me_req_ready = in_idle && grant_me;
  assign req_hs       = if_req_ready || me_req_ready;

  assign mem_req_valid = in_req;
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

  assign mem_rsp_ready = in_resp &&
                         (sel ? me_rsp_ready : if_rsp_ready);
  assign rsp_hs        = mem_rsp_valid && mem_rsp_ready;

  assign if_rsp_valid = in_resp && !sel && mem_rsp_valid;
  assign me_rsp_valid = in_resp && sel && mem_rsp_valid;
  assign if_rsp_rdata = mem_rsp_rdata;
  assign me_rsp_rdata = mem_rsp_rdata;
  assign if_rsp_err   = in_resp && !sel && mem_rsp_err;
  assign me_rsp_err   = in_resp && sel && mem_rsp_err;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_hs) state_nxt = REQ;
      REQ:     if (mem_req_ready) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= 1'b0;
      last    <= 1'b1;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state <= state_nxt;
      if (req_hs) begin
        sel <= grant_me;
        if (grant_me) begin
          addr_q  <= me_req_addr;
          wen_q   <= me_req_wen;
          wdata_q <= me_req_wdata;
          wstrb_q <= me_req_wstrb;
        end else begin
          addr_q  <= if_req_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wstrb_q <= '0;
        end
      end
      if (rsp_hs) last <= sel;
    end
  end

endmodule
